// File: rtl/uart_rx2_pkg.sv
// Shared definitions for the UART pair: default clock rate, bit-period math, FSM states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_rx2_pkg;

  localparam int CLK_FREQ_DEFAULT  = 12_000_000;
  localparam int UART_BAUD_DEFAULT = 9600;

  // Integer divide: any fractional remainder shows up as a small baud error.
  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } rx_state_t;

endpackage

// File: rtl/uart_rx2_sync.sv
// Two-flop synchroniser for an asynchronous single-bit line, reset value parameterised.
// Latency: 2 ICE_CLK cycles from line to line_s.
// Backpressure: none; free-running.
// Ports: ICE_CLK clock, RST_N async active-low reset, line raw input, line_s synchronised output.
module uart_rx2_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic ICE_CLK,
  input  logic RST_N,
  input  logic line,
  output logic line_s
);

  logic meta;

  always_ff @(posedge ICE_CLK or negedge RST_N) begin
    if (!RST_N) begin
      meta   <= RST_VAL;
      line_s <= RST_VAL;
    end else begin
      meta   <= line;
      line_s <= meta;
    end
  end

endmodule

// File: rtl/uart_rx2.sv
// 8N1 UART receiver: synchronise, validate start, 3-sample majority vote per bit, check stop.
// Latency: RX_DV rises 2 + 9*CLKS_PER_BIT + MID + 1 cycles after the line's start edge.
// Backpressure: none; RX_BYTE is overwritten by the next good frame whether or not it was consumed.
// Ports: ICE_CLK clock, RST_N async active-low reset, UART_RX raw serial line (idle high),
//        RX_BYTE last good byte, RX_DV 1-cycle byte strobe, FRAME_ERR 1-cycle bad-stop strobe,
//        BUSY high while a frame is being received (or while a break holds the line low).
module uart_rx2
  import uart_rx2_pkg::*;
#(
  parameter int CLK_FREQ  = CLK_FREQ_DEFAULT,
  parameter int UART_BAUD = UART_BAUD_DEFAULT
) (
  input  logic       ICE_CLK,
  input  logic       RST_N,
  input  logic       UART_RX,
  output logic [7:0] RX_BYTE,
  output logic       RX_DV,
  output logic       FRAME_ERR,
  output logic       BUSY
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, UART_BAUD);
  localparam int MID          = CLKS_PER_BIT / 2;
  localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] SAMP_A   = CNT_W'(MID - 1);
  localparam logic [CNT_W-1:0] SAMP_B   = CNT_W'(MID);
  localparam logic [CNT_W-1:0] SAMP_C   = CNT_W'(MID + 1);

  logic             rx_s;
  logic [1:0]       warm;
  logic             armed;
  rx_state_t        state, state_nxt;
  logic [CNT_W-1:0] clk_cnt, clk_cnt_nxt;
  logic [2:0]       bit_idx, bit_idx_nxt;
  logic [7:0]       shreg, shreg_nxt;
  logic [7:0]       byte_nxt;
  logic             dv_nxt, ferr_nxt;
  logic             samp_a, samp_b;
  logic             vote, vote_now;

  uart_rx2_sync #(.RST_VAL(1'b1)) u_sync (
    .ICE_CLK (ICE_CLK),
    .RST_N   (RST_N),
    .line    (UART_RX),
    .line_s  (rx_s)
  );

  // The synchroniser holds its reset value for two edges. warm marks when rx_s
  // reflects the real line; armed then requires one genuine high before any start
  // is accepted, so a line already low at reset release is not taken as a frame.
  always_ff @(posedge ICE_CLK or negedge RST_N) begin
    if (!RST_N) begin
      warm  <= 2'b00;
      armed <= 1'b0;
    end else begin
      warm  <= {warm[0], 1'b1};
      armed <= armed | (warm[1] & rx_s);
    end
  end

  // First two of the three votes are captured; the third is rx_s live at SAMP_C.
  always_ff @(posedge ICE_CLK or negedge RST_N) begin
    if (!RST_N) begin
      samp_a <= 1'b1;
      samp_b <= 1'b1;
    end else begin
      if (clk_cnt == SAMP_A) samp_a <= rx_s;
      if (clk_cnt == SAMP_B) samp_b <= rx_s;
    end
  end

  assign vote     = majority3(samp_a, samp_b, rx_s);
  assign vote_now = (clk_cnt == SAMP_C);

  always_ff @(posedge ICE_CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= ST_IDLE;
      clk_cnt   <= '0;
      bit_idx   <= '0;
      shreg     <= 8'h00;
      RX_BYTE   <= 8'h00;
      RX_DV     <= 1'b0;
      FRAME_ERR <= 1'b0;
    end else begin
      state     <= state_nxt;
      clk_cnt   <= clk_cnt_nxt;
      bit_idx   <= bit_idx_nxt;
      shreg     <= shreg_nxt;
      RX_BYTE   <= byte_nxt;
      RX_DV     <= dv_nxt;
      FRAME_ERR <= ferr_nxt;
    end
  end

  // clk_cnt free-runs modulo CLKS_PER_BIT from the start detect, so every vote
  // after the start-bit vote lands exactly one bit period later, mid-bit.
  always_comb begin
    state_nxt   = state;
    clk_cnt_nxt = (clk_cnt == CNT_LAST) ? '0 : clk_cnt + CNT_W'(1);
    bit_idx_nxt = bit_idx;
    shreg_nxt   = shreg;
    byte_nxt    = RX_BYTE;
    dv_nxt      = 1'b0;
    ferr_nxt    = 1'b0;

    unique case (state)
      ST_IDLE: begin
        // The detect cycle itself counts as clk_cnt 0, hence the load of 1.
        clk_cnt_nxt = '0;
        if (armed && !rx_s) begin
          state_nxt   = ST_START;
          clk_cnt_nxt = CNT_W'(1);
        end
      end
      ST_START: begin
        if (vote_now) begin
          if (vote) begin
            state_nxt   = ST_IDLE;
            clk_cnt_nxt = '0;
          end else begin
            state_nxt   = ST_DATA;
            bit_idx_nxt = 3'd0;
          end
        end
      end
      ST_DATA: begin
        if (vote_now) begin
          shreg_nxt[bit_idx] = vote;
          bit_idx_nxt        = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_nxt = ST_STOP;
        end
      end
      ST_STOP: begin
        // Leaving at mid stop bit leaves half a bit of slack for a back-to-back start.
        if (vote_now) begin
          clk_cnt_nxt = '0;
          if (vote) begin
            byte_nxt  = shreg;
            dv_nxt    = 1'b1;
            state_nxt = ST_IDLE;
          end else begin
            ferr_nxt  = 1'b1;
            state_nxt = ST_BREAK;
          end
        end
      end
      ST_BREAK: begin
        clk_cnt_nxt = '0;
        if (rx_s) state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt   = ST_IDLE;
        clk_cnt_nxt = '0;
      end
    endcase
  end

  assign BUSY = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx2.sv
module tb_uart_rx2;

  localparam int CPB = 40;                    // 12 MHz / 300 kbaud
  localparam int MID = CPB / 2;
  localparam int LAT = 2 + 9 * CPB + MID + 1; // start edge to RX_DV / FRAME_ERR

  logic       ICE_CLK = 1'b0;
  logic       RST_N   = 1'b0;
  logic       UART_RX = 1'b1;
  logic [7:0] RX_BYTE;
  logic       RX_DV, FRAME_ERR, BUSY;

  uart_rx2 #(.CLK_FREQ(12_000_000), .UART_BAUD(300_000)) dut (
    .ICE_CLK   (ICE_CLK),
    .RST_N     (RST_N),
    .UART_RX   (UART_RX),
    .RX_BYTE   (RX_BYTE),
    .RX_DV     (RX_DV),
    .FRAME_ERR (FRAME_ERR),
    .BUSY      (BUSY)
  );

  always #5 ICE_CLK = ~ICE_CLK;

  int cyc = 0;
  always @(posedge ICE_CLK) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference model: every frame sent queues the event it must produce and when.
  typedef struct {
    bit         is_err;
    logic [7:0] b;
    int         t;
  } ev_t;

  ev_t        exp_q[$];
  ev_t        e_cur;
  logic [7:0] last_good   = 8'h00;
  int         dv_cnt      = 0;
  int         fe_cnt      = 0;
  int         last_ev_cyc = 0;

  always @(negedge ICE_CLK) begin
    if (!RST_N) begin
      last_good = 8'h00;
    end else begin
      if (RX_DV || FRAME_ERR) begin
        chk("dv_fe_exclusive", 32'(RX_DV & FRAME_ERR), 32'd0);
        if (exp_q.size() == 0) begin
          chk("unexpected_event", 32'({RX_DV, FRAME_ERR}), 32'd0);
        end else begin
          e_cur = exp_q.pop_front();
          chk("event_kind", 32'(FRAME_ERR), 32'(e_cur.is_err));
          chk("event_time", 32'(cyc), 32'(e_cur.t));
          chk("busy_at_event", 32'(BUSY), 32'(e_cur.is_err));
          if (RX_DV) begin
            last_good = e_cur.b;
            dv_cnt++;
          end else begin
            fe_cnt++;
          end
          last_ev_cyc = cyc;
        end
      end else if (exp_q.size() > 0 && cyc > exp_q[0].t) begin
        chk("missed_event", 32'(cyc), 32'(exp_q[0].t));
        e_cur = exp_q.pop_front();
      end
      chk("rx_byte", 32'(RX_BYTE), 32'(last_good));
    end
  end

  // All driving happens just after a rising edge (or on a falling edge).
  task automatic hold(input logic lvl, input int n);
    UART_RX = lvl;
    repeat (n) @(posedge ICE_CLK);
    #1;
  endtask

  task automatic to_cyc(input int c);
    while (cyc < c) @(negedge ICE_CLK);
  endtask

  // Cycle at which bit i begins for a sender running pct percent fast.
  function automatic int bnd(input int i, input int pct);
    return (i * CPB * 100) / (100 + pct);
  endfunction

  // Bad-stop frames leave the line low afterwards; the caller raises it.
  task automatic send_frame(input logic [7:0] b, input int pct, input bit bad_stop,
                            input int extra_low_bits, input bit spikes);
    logic [9:0] bits;
    ev_t        e;
    int         n;
    bits     = {~bad_stop, b, 1'b0};
    e.is_err = bad_stop;
    e.b      = b;
    e.t      = cyc + 1 + LAT;
    exp_q.push_back(e);
    for (int i = 0; i < 10; i++) begin
      n = bnd(i + 1, pct) - bnd(i, pct);
      if (spikes && i >= 1 && i <= 8) begin
        hold(bits[i], n / 2);
        hold(~bits[i], 1);
        hold(bits[i], n - n / 2 - 1);
      end else begin
        hold(bits[i], n);
      end
    end
    if (bad_stop) hold(1'b0, extra_low_bits * CPB);
  endtask

  task automatic rand_frames(input int count);
    logic [7:0] b;
    int         pct;
    bit         bad;
    bit         spk;
    for (int k = 0; k < count; k++) begin
      b   = 8'($urandom);
      pct = int'($urandom_range(6)) - 3;
      bad = ($urandom_range(7) == 0);
      spk = 1'($urandom_range(1));
      send_frame(b, pct, bad, bad ? int'($urandom_range(3)) : 0, spk);
      if (bad) hold(1'b1, 4 + int'($urandom_range(CPB)));
      else if ($urandom_range(2) == 0) hold(1'b1, 0);
      else hold(1'b1, int'($urandom_range(2 * CPB)));
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  logic [7:0] t1_bytes [4];
  int t0, dv0, fe0;

  initial begin
    t1_bytes[0] = 8'h41; t1_bytes[1] = 8'h00; t1_bytes[2] = 8'hFF; t1_bytes[3] = 8'h55;

    // Reset state
    repeat (3) @(posedge ICE_CLK);
    #1;
    chk("reset_rx_byte", 32'(RX_BYTE), 32'h00);
    chk("reset_rx_dv", 32'(RX_DV), 32'd0);
    chk("reset_frame_err", 32'(FRAME_ERR), 32'd0);
    chk("reset_busy", 32'(BUSY), 32'd0);
    RST_N = 1'b1;
    hold(1'b1, 10);

    // Exact-baud single frames
    dv0 = dv_cnt; fe0 = fe_cnt;
    for (int k = 0; k < 4; k++) begin
      t0 = cyc + 1;
      send_frame(t1_bytes[k], 0, 1'b0, 0, 1'b0);
      hold(1'b1, 2 * CPB);
      chk("t1_byte", 32'(RX_BYTE), 32'(t1_bytes[k]));
      if (k == 0) chk("t1_latency", 32'(last_ev_cyc - t0), 32'd383);
    end
    chk("t1_dv_count", 32'(dv_cnt - dv0), 32'd4);
    chk("t1_fe_count", 32'(fe_cnt - fe0), 32'd0);

    // Back-to-back frames, no idle gap
    dv0 = dv_cnt;
    for (int k = 0; k < 10; k++) send_frame(8'h30 + 8'(k), 0, 1'b0, 0, 1'b0);
    hold(1'b1, 2 * CPB);
    chk("t2_dv_count", 32'(dv_cnt - dv0), 32'd10);
    chk("t2_last_byte", 32'(RX_BYTE), 32'h39);
    chk("t2_fe_count", 32'(fe_cnt - fe0), 32'd0);

    // Short low glitch on an idle line
    t0 = cyc + 1;
    UART_RX = 1'b0;
    to_cyc(t0 + 2);
    chk("t3_busy_on_detect", 32'(BUSY), 32'd1);
    to_cyc(t0 + 9);
    UART_RX = 1'b1;
    to_cyc(t0 + 2 + MID + 2);
    chk("t3_busy_cleared", 32'(BUSY), 32'd0);
    @(posedge ICE_CLK);
    #1;
    hold(1'b1, 2 * CPB);

    // Bad stop bit followed by a long break
    fe0 = fe_cnt;
    send_frame(8'hA5, 0, 1'b1, 20, 1'b0);
    chk("t4_busy_in_break", 32'(BUSY), 32'd1);
    chk("t4_fe_count", 32'(fe_cnt - fe0), 32'd1);
    chk("t4_byte_kept", 32'(RX_BYTE), 32'h39);
    hold(1'b1, 4);
    chk("t4_busy_after_break", 32'(BUSY), 32'd0);
    send_frame(8'h5A, 0, 1'b0, 0, 1'b0);
    hold(1'b1, 2 * CPB);
    chk("t4_recovery_byte", 32'(RX_BYTE), 32'h5A);

    // Sender baud skew with single-cycle noise spikes
    send_frame(8'h0F, 3, 1'b0, 0, 1'b1);
    hold(1'b1, CPB);
    chk("t5_fast_byte", 32'(RX_BYTE), 32'h0F);
    send_frame(8'hF0, -3, 1'b0, 0, 1'b1);
    hold(1'b1, CPB);
    chk("t5_slow_byte", 32'(RX_BYTE), 32'hF0);

    // Reset during data bit 4 of 8'hC3 (bits LSB first: 1,1,0,0,0,...)
    hold(1'b0, CPB);
    hold(1'b1, CPB);
    hold(1'b1, CPB);
    hold(1'b0, CPB);
    hold(1'b0, CPB);
    hold(1'b0, MID);
    RST_N = 1'b0;
    #1;
    chk("t6_rst_rx_byte", 32'(RX_BYTE), 32'h00);
    chk("t6_rst_rx_dv", 32'(RX_DV), 32'd0);
    chk("t6_rst_frame_err", 32'(FRAME_ERR), 32'd0);
    chk("t6_rst_busy", 32'(BUSY), 32'd0);
    repeat (5) @(posedge ICE_CLK);
    #1;
    RST_N = 1'b1;
    hold(1'b0, 3 * CPB);
    chk("t6_no_false_start", 32'(BUSY), 32'd0);
    hold(1'b1, 10);
    send_frame(8'h3C, 0, 1'b0, 0, 1'b0);
    hold(1'b1, 2 * CPB);
    chk("t6_after_reset_byte", 32'(RX_BYTE), 32'h3C);

    // Randomised traffic
    rand_frames(25);
    hold(1'b1, 2 * CPB);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
